// File: rtl/cpu_control_sequencer_pkg.sv
// Shared definitions for the multi-cycle control sequencer: state encoding,
// opcode values, opcode-class groups and instruction field extractors.
package cpu_control_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_HALT   = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      CL_ALU,
      CL_IMM,
      CL_LD,
      CL_ST,
      CL_BRZ,
      CL_JMP,
      CL_HALT,
      CL_ILLEGAL
   } op_class_t;

   localparam logic [6:0] OP_LD   = 7'b0010000;
   localparam logic [6:0] OP_ST   = 7'b0100000;
   localparam logic [6:0] OP_BRZ  = 7'b1100000;
   localparam logic [6:0] OP_JMP  = 7'b1110000;
   localparam logic [6:0] OP_HALT = 7'b1111111;

   localparam logic [1:0] GRP_ALU = 2'b00;
   localparam logic [1:0] GRP_IMM = 2'b10;

   function automatic logic [6:0] op_field(input logic [15:0] ir);
      return ir[15:9];
   endfunction

   function automatic logic [2:0] dr_field(input logic [15:0] ir);
      return ir[8:6];
   endfunction

   function automatic logic [2:0] sa_field(input logic [15:0] ir);
      return ir[5:3];
   endfunction

   function automatic logic [2:0] sb_field(input logic [15:0] ir);
      return ir[2:0];
   endfunction

endpackage

// File: rtl/cpu_instr_decoder.sv
// Combinational instruction decode: opcode class, ALU function, zero-extended
// immediate and sign-extended 6-bit branch offset.
module cpu_instr_decoder
   import cpu_control_sequencer_pkg::*;
#(
   parameter int PC_W   = 8,
   parameter int DATA_W = 16
) (
   input  logic [15:0]             ir,
   output op_class_t               op_class,
   output logic [4:0]              fs,
   output logic [DATA_W-1:0]       imm,
   output logic signed [PC_W-1:0]  br_off
);

   logic [6:0]        op;
   logic signed [5:0] off6;

   assign op   = op_field(ir);
   assign fs   = op[4:0];
   assign imm  = {{(DATA_W-3){1'b0}}, sb_field(ir)};
   assign off6 = {dr_field(ir), sb_field(ir)};
   assign br_off = {{(PC_W-6){off6[5]}}, off6};

   // Exact opcodes take priority over the ALU/IMM groups they fall inside.
   always_comb begin
      op_class = CL_ILLEGAL;
      if (op == OP_LD)
         op_class = CL_LD;
      else if (op == OP_ST)
         op_class = CL_ST;
      else if (op == OP_BRZ)
         op_class = CL_BRZ;
      else if (op == OP_JMP)
         op_class = CL_JMP;
      else if (op == OP_HALT)
         op_class = CL_HALT;
      else if (op[6:5] == GRP_ALU)
         op_class = CL_ALU;
      else if (op[6:5] == GRP_IMM)
         op_class = CL_IMM;
   end

endmodule

// File: rtl/cpu_control_sequencer.sv
// Multi-cycle control FSM: owns PC and IR, sequences FETCH/DECODE/EXEC/MEM/HALT
// and drives register-file, ALU and memory-handshake controls.
module cpu_control_sequencer
   import cpu_control_sequencer_pkg::*;
#(
   parameter int              PC_W     = 8,
   parameter int              DATA_W   = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   output logic [PC_W-1:0]   imem_addr,
   output logic              imem_req,
   input  logic              imem_ready,
   input  logic [15:0]       instr,
   input  logic              zero_flag,
   input  logic [DATA_W-1:0] a_data,
   output logic [2:0]        AA,
   output logic [2:0]        BB,
   output logic [2:0]        DA,
   output logic              RW,
   output logic              MB,
   output logic              MD,
   output logic [4:0]        FS,
   output logic              dmem_req,
   output logic              MW,
   input  logic              dmem_ack,
   output logic [DATA_W-1:0] imm,
   output logic              halted,
   output logic              illegal_op
);

   state_t                  state;
   logic [PC_W-1:0]         pc;
   logic [15:0]             ir;
   op_class_t               op_class;
   logic [4:0]              dec_fs;
   logic [DATA_W-1:0]       dec_imm;
   logic signed [PC_W-1:0]  br_off;
   logic [PC_W-1:0]         pc_inc;
   logic                    unused_a_data;

   assign pc_inc        = pc + PC_W'(1);
   assign unused_a_data = ^a_data[DATA_W-1:PC_W];

   cpu_instr_decoder #(
      .PC_W   (PC_W),
      .DATA_W (DATA_W)
   ) u_decoder (
      .ir       (ir),
      .op_class (op_class),
      .fs       (dec_fs),
      .imm      (dec_imm),
      .br_off   (br_off)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_FETCH;
         pc    <= RESET_PC;
         ir    <= '0;
      end else begin
         case (state)
            ST_FETCH: begin
               if (imem_ready) begin
                  ir    <= instr;
                  state <= ST_DECODE;
               end
            end
            ST_DECODE: state <= ST_EXEC;
            ST_EXEC: begin
               case (op_class)
                  CL_LD, CL_ST: state <= ST_MEM;
                  CL_BRZ: begin
                     pc    <= zero_flag ? pc + $unsigned(br_off) : pc_inc;
                     state <= ST_FETCH;
                  end
                  CL_JMP: begin
                     pc    <= a_data[PC_W-1:0];
                     state <= ST_FETCH;
                  end
                  CL_HALT: state <= ST_HALT;
                  default: begin
                     pc    <= pc_inc;
                     state <= ST_FETCH;
                  end
               endcase
            end
            ST_MEM: begin
               if (dmem_ack) begin
                  pc    <= pc_inc;
                  state <= ST_FETCH;
               end
            end
            ST_HALT: state <= ST_HALT;
            default: state <= ST_FETCH;
         endcase
      end
   end

   // Outputs are gated by reset so requests and writes drop in the reset cycle itself.
   always_comb begin
      imem_addr  = pc;
      imem_req   = 1'b0;
      AA         = '0;
      BB         = '0;
      DA         = '0;
      RW         = 1'b0;
      MB         = 1'b0;
      MD         = 1'b0;
      FS         = '0;
      dmem_req   = 1'b0;
      MW         = 1'b0;
      imm        = '0;
      halted     = 1'b0;
      illegal_op = 1'b0;
      if (reset) begin
         imem_addr = RESET_PC;
      end else begin
         if (state inside {ST_DECODE, ST_EXEC, ST_MEM}) begin
            AA  = sa_field(ir);
            BB  = sb_field(ir);
            DA  = dr_field(ir);
            imm = dec_imm;
         end
         case (state)
            ST_FETCH: imem_req = 1'b1;
            ST_EXEC: begin
               case (op_class)
                  CL_ALU: begin
                     FS = dec_fs;
                     RW = 1'b1;
                  end
                  CL_IMM: begin
                     FS = dec_fs;
                     MB = 1'b1;
                     RW = 1'b1;
                  end
                  CL_LD: dmem_req = 1'b1;
                  CL_ST: begin
                     dmem_req = 1'b1;
                     MW       = 1'b1;
                  end
                  CL_ILLEGAL: illegal_op = 1'b1;
                  default: ;
               endcase
            end
            ST_MEM: begin
               dmem_req = 1'b1;
               MW       = (op_class == CL_ST);
               if (dmem_ack && op_class == CL_LD) begin
                  RW = 1'b1;
                  MD = 1'b1;
               end
            end
            ST_HALT: halted = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Bench for cpu_control_sequencer: directed and random instruction streams checked
// against an instruction-level model of PC and per-cycle control outputs.
module tb_cpu_control_sequencer;

   localparam int         PC_W   = 8;
   localparam int         DATA_W = 16;
   localparam logic [7:0] RST_PC = 8'h10;

   localparam int K_ALU = 0, K_IMM = 1, K_LD = 2, K_ST = 3, K_BRZ = 4, K_JMP = 5, K_HALT = 6, K_ILL = 7;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [PC_W-1:0]   imem_addr;
   logic              imem_req;
   logic              imem_ready = 1'b0;
   logic [15:0]       instr = '0;
   logic              zero_flag = 1'b0;
   logic [DATA_W-1:0] a_data = '0;
   logic [2:0]        AA, BB, DA;
   logic              RW, MB, MD, MW;
   logic [4:0]        FS;
   logic              dmem_req;
   logic              dmem_ack = 1'b0;
   logic [DATA_W-1:0] imm;
   logic              halted, illegal_op;

   int         errors = 0;
   int         checks = 0;
   logic [7:0] m_pc;

   cpu_control_sequencer #(
      .PC_W     (PC_W),
      .DATA_W   (DATA_W),
      .RESET_PC (RST_PC)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .imem_addr  (imem_addr),
      .imem_req   (imem_req),
      .imem_ready (imem_ready),
      .instr      (instr),
      .zero_flag  (zero_flag),
      .a_data     (a_data),
      .AA         (AA),
      .BB         (BB),
      .DA         (DA),
      .RW         (RW),
      .MB         (MB),
      .MD         (MD),
      .FS         (FS),
      .dmem_req   (dmem_req),
      .MW         (MW),
      .dmem_ack   (dmem_ack),
      .imm        (imm),
      .halted     (halted),
      .illegal_op (illegal_op)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int kind(input logic [6:0] op);
      if (op == 7'h10) return K_LD;
      if (op == 7'h20) return K_ST;
      if (op == 7'h60) return K_BRZ;
      if (op == 7'h70) return K_JMP;
      if (op == 7'h7F) return K_HALT;
      if (op[6:5] == 2'b00) return K_ALU;
      if (op[6:5] == 2'b10) return K_IMM;
      return K_ILL;
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      imem_ready = 1'b0;
      dmem_ack = 1'b0;
      @(posedge clk); #1;
      check("rst_addr", 32'(imem_addr), 32'(RST_PC));
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_rw", 32'(RW), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_dreq", 32'(dmem_req), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      m_pc = RST_PC;
      check("post_rst_req", 32'(imem_req), 32'd1);
      check("post_rst_addr", 32'(imem_addr), 32'(RST_PC));
      check("post_rst_rw", 32'(RW), 32'd0);
   endtask

   task automatic fetch_decode(input logic [15:0] ins, input int rdy_wait);
      for (int i = 0; i < rdy_wait; i++) begin
         imem_ready = 1'b0;
         instr = 16'($urandom);
         #1;
         check("fetch_wait_req", 32'(imem_req), 32'd1);
         check("fetch_wait_pc", 32'(imem_addr), 32'(m_pc));
         @(posedge clk); #1;
      end
      imem_ready = 1'b1;
      instr = ins;
      #1;
      check("fetch_req", 32'(imem_req), 32'd1);
      check("fetch_pc", 32'(imem_addr), 32'(m_pc));
      check("fetch_rw", 32'(RW), 32'd0);
      check("fetch_dreq", 32'(dmem_req), 32'd0);
      check("fetch_ill", 32'(illegal_op), 32'd0);
      @(posedge clk); #1;
      imem_ready = 1'b0;
      instr = 16'($urandom);
      #1;
      check("dec_req", 32'(imem_req), 32'd0);
      check("dec_aa", 32'(AA), 32'(ins[5:3]));
      check("dec_bb", 32'(BB), 32'(ins[2:0]));
      check("dec_rw", 32'(RW), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic exec_instr(input logic [15:0] ins, input logic zf, input logic [15:0] ad, input int ack_wait);
      logic [6:0] op;
      int         k;
      int         off;
      logic       is_mem;
      op = ins[15:9];
      k = kind(op);
      is_mem = (k == K_LD) || (k == K_ST);
      zero_flag = zf;
      a_data = ad;
      #1;
      check("ex_rw", 32'(k == K_ALU || k == K_IMM), 32'(RW) ^ 32'd0);
      if (k == K_ALU || k == K_IMM) begin
         check("ex_da", 32'(DA), 32'(ins[8:6]));
         check("ex_fs", 32'(FS), 32'(op[4:0]));
      end
      check("ex_mb", 32'(MB), 32'(k == K_IMM));
      if (k == K_IMM) check("ex_imm", 32'(imm), 32'(ins[2:0]));
      check("ex_dreq", 32'(dmem_req), 32'(is_mem));
      check("ex_mw", 32'(MW), 32'(k == K_ST));
      check("ex_md", 32'(MD), 32'd0);
      check("ex_ill", 32'(illegal_op), 32'(k == K_ILL));
      check("ex_halted", 32'(halted), 32'd0);
      case (k)
         K_LD, K_ST: begin
            for (int w = 0; w <= ack_wait; w++) begin
               @(posedge clk); #1;
               dmem_ack = (w == ack_wait);
               #1;
               check("mem_dreq", 32'(dmem_req), 32'd1);
               check("mem_mw", 32'(MW), 32'(k == K_ST));
               check("mem_rw", 32'(RW), 32'(k == K_LD && w == ack_wait));
               check("mem_md", 32'(MD), 32'(k == K_LD && w == ack_wait));
               if (k == K_LD && w == ack_wait) check("mem_da", 32'(DA), 32'(ins[8:6]));
            end
            m_pc = m_pc + 8'd1;
         end
         K_BRZ: begin
            if (zf) begin
               off = int'(ins[8:6]) * 8 + int'(ins[2:0]);
               if (off >= 32) off = off - 64;
               m_pc = 8'((int'(m_pc) + off + 256) % 256);
            end else begin
               m_pc = m_pc + 8'd1;
            end
         end
         K_JMP: m_pc = ad[7:0];
         K_HALT: ;
         default: m_pc = m_pc + 8'd1;
      endcase
      if (k != K_HALT) begin
         @(posedge clk); #1;
         dmem_ack = 1'b0;
      end
   endtask

   task automatic run_instr(input logic [15:0] ins, input logic zf, input logic [15:0] ad,
                            input int rdy_wait, input int ack_wait);
      fetch_decode(ins, rdy_wait);
      exec_instr(ins, zf, ad, ack_wait);
   endtask

   initial begin
      logic [15:0] ins;
      logic [6:0]  op;

      do_reset();

      // ALU: DR=3, SA=1, SB=2, FS=5
      run_instr({7'b0000101, 3'd3, 3'd1, 3'd2}, 1'b0, 16'h0000, 0, 0);
      // LD DR=4 with ack two cycles after request
      run_instr({7'h10, 3'd4, 3'd2, 3'd5}, 1'b0, 16'h0000, 1, 1);
      // ST zero-wait
      run_instr({7'h20, 3'd1, 3'd6, 3'd7}, 1'b0, 16'h0000, 0, 0);
      // IMM class
      run_instr({7'b1000011, 3'd2, 3'd0, 3'd5}, 1'b0, 16'h0000, 0, 0);
      // JMP to 0 then BRZ -2 taken
      run_instr({7'h70, 3'd0, 3'd5, 3'd0}, 1'b0, 16'hAB00, 0, 0);
      run_instr({7'h60, 3'd7, 3'd0, 3'd6}, 1'b1, 16'h0000, 0, 0);
      // JMP to 0 then BRZ -2 not taken
      run_instr({7'h70, 3'd0, 3'd5, 3'd0}, 1'b0, 16'h1200, 0, 0);
      run_instr({7'h60, 3'd7, 3'd0, 3'd6}, 1'b0, 16'h0000, 0, 0);
      // undefined opcode
      run_instr({7'h30, 3'd1, 3'd1, 3'd1}, 1'b0, 16'h0000, 0, 0);
      // PC wrap 0xFF -> 0x00
      run_instr({7'h70, 3'd0, 3'd2, 3'd0}, 1'b0, 16'h00FF, 0, 0);
      run_instr({7'b0000001, 3'd5, 3'd5, 3'd5}, 1'b0, 16'h0000, 0, 0);
      fetch_decode({7'b0000010, 3'd1, 3'd2, 3'd3}, 0);
      exec_instr({7'b0000010, 3'd1, 3'd2, 3'd3}, 1'b0, 16'h0000, 0);

      for (int n = 0; n < 120; n++) begin
         case ($urandom_range(0, 5))
            0: op = 7'h10;
            1: op = 7'h20;
            2: op = 7'h60;
            3: op = 7'h70;
            default: begin
               op = 7'($urandom);
               if (op == 7'h7F) op = 7'h00;
            end
         endcase
         ins = {op, 9'($urandom)};
         run_instr(ins, 1'($urandom), 16'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
      end

      // reset during MEM with ack pending aborts the load
      fetch_decode({7'h10, 3'd6, 3'd1, 3'd1}, 0);
      #1;
      check("abort_ex_dreq", 32'(dmem_req), 32'd1);
      @(posedge clk); #1;
      reset = 1'b1;
      dmem_ack = 1'b1;
      #1;
      check("abort_dreq", 32'(dmem_req), 32'd0);
      check("abort_rw", 32'(RW), 32'd0);
      check("abort_md", 32'(MD), 32'd0);
      check("abort_addr", 32'(imem_addr), 32'(RST_PC));
      @(posedge clk); #1;
      reset = 1'b0;
      dmem_ack = 1'b0;
      #1;
      m_pc = RST_PC;
      check("abort_restart_req", 32'(imem_req), 32'd1);
      check("abort_restart_pc", 32'(imem_addr), 32'(RST_PC));
      check("abort_restart_rw", 32'(RW), 32'd0);

      // HALT: sticky until reset
      run_instr({7'h7F, 3'd0, 3'd0, 3'd0}, 1'b0, 16'h0000, 0, 0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         imem_ready = 1'b1;
         instr = 16'($urandom);
         #1;
         check("halt_halted", 32'(halted), 32'd1);
         check("halt_req", 32'(imem_req), 32'd0);
         check("halt_rw", 32'(RW), 32'd0);
         check("halt_dreq", 32'(dmem_req), 32'd0);
      end
      do_reset();
      check("halt_cleared", 32'(halted), 32'd0);
      run_instr({7'b0000111, 3'd2, 3'd3, 3'd4}, 1'b0, 16'h0000, 0, 0);
      fetch_decode({7'b0000000, 3'd0, 3'd0, 3'd0}, 0);
      exec_instr({7'b0000000, 3'd0, 3'd0, 3'd0}, 1'b0, 16'h0000, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
